// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and next-PC selection for the
// single-cycle MIPS datapath. Owns the supervisor bit PC[31], the pending
// interrupt latch and the fetch-stall hold.
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   PCSrc           - next-PC select: 0 PC+4, 1 branch, 2 jump, 3 jump-register
//   BranchTaken     - branch condition, used only when PCSrc==1
//   ConBA           - branch target from the extension stage
//   JT              - 26-bit jump field
//   DatabusA        - rs value for jr/jalr
//   Exc             - illegal/undefined instruction this cycle
//   IRQ             - level interrupt request
//   Stall           - instruction memory not ready; hold PC
//   PC, PCplus4     - current address and its sequential successor
//   IntTaken        - this cycle redirects to ILLOP_PC
//   ExcTaken        - this cycle redirects to XADR_PC
//   EPC             - return address for $k0 on a redirect
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PCSrc,
    input  logic        BranchTaken,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] DatabusA,
    input  logic        Exc,
    input  logic        IRQ,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        IntTaken,
    output logic        ExcTaken,
    output logic [31:0] EPC
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        irq_pend_q;
    logic        irq_pend_d;
    logic        kernel;

    assign PC      = pc_q;
    assign kernel  = pc_q[31];
    // Carry out of bit 30 is dropped so sequential fetch never changes mode.
    assign PCplus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    assign ExcTaken = Exc & ~Stall;
    // Interrupts are masked in kernel mode and lose to a concurrent exception.
    assign IntTaken = irq_pend_q & ~kernel & ~Exc & ~Stall;
    assign EPC      = ExcTaken ? PCplus4 : pc_q;

    always_comb begin
        pc_d = PCplus4;
        if (Stall) begin
            pc_d = pc_q;
        end else if (ExcTaken) begin
            pc_d = XADR_PC;
        end else if (IntTaken) begin
            pc_d = ILLOP_PC;
        end else begin
            unique case (PCSrc)
                2'd0: pc_d = PCplus4;
                2'd1: pc_d = BranchTaken ? {pc_q[31], ConBA[30:0]} : PCplus4;
                2'd2: pc_d = {pc_q[31], PCplus4[30:28], JT, 2'b00};
                // jr may drop to user mode but can never raise privilege.
                2'd3: pc_d = {pc_q[31] & DatabusA[31], DatabusA[30:0]};
                default: pc_d = PCplus4;
            endcase
        end
    end

    // A new request on the taking edge re-pends the interrupt.
    assign irq_pend_d = IRQ | (irq_pend_q & ~IntTaken);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            irq_pend_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            irq_pend_q <= irq_pend_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCSrc;
    logic        BranchTaken;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] DatabusA;
    logic        Exc;
    logic        IRQ;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        IntTaken;
    logic        ExcTaken;
    logic [31:0] EPC;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .BranchTaken (BranchTaken),
        .ConBA       (ConBA),
        .JT          (JT),
        .DatabusA    (DatabusA),
        .Exc         (Exc),
        .IRQ         (IRQ),
        .Stall       (Stall),
        .PC          (PC),
        .PCplus4     (PCplus4),
        .IntTaken    (IntTaken),
        .ExcTaken    (ExcTaken),
        .EPC         (EPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  src;
        logic        bt;
        logic [31:0] conba;
        logic [25:0] jt;
        logic [31:0] dba;
        logic        exc;
        logic        irq;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_int;
        logic        e_exc;
        logic        e_pend;   // pending latch after the edge
    } row_t;

    function automatic row_t mk(logic rst, logic stall, logic [1:0] src, logic bt,
                                logic [31:0] conba, logic [25:0] jt, logic [31:0] dba,
                                logic exc, logic irq, logic [31:0] e_pc, logic [31:0] e_p4,
                                logic e_int, logic e_exc, logic e_pend);
        row_t r;
        r.rst = rst; r.stall = stall; r.src = src; r.bt = bt; r.conba = conba;
        r.jt = jt; r.dba = dba; r.exc = exc; r.irq = irq; r.e_pc = e_pc;
        r.e_p4 = e_p4; r.e_int = e_int; r.e_exc = e_exc; r.e_pend = e_pend;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic [1:0] src,
                         input logic bt, input logic [31:0] conba, input logic [25:0] jt,
                         input logic [31:0] dba, input logic exc, input logic irq);
        reset = rst; Stall = stall; PCSrc = src; BranchTaken = bt; ConBA = conba;
        JT = jt; DatabusA = dba; Exc = exc; IRQ = irq;
    endtask

    // Apply one row: drive at negedge, check combinational outputs, then the edge.
    task automatic apply(input row_t r, input string tag);
        @(negedge clk);
        drive(r.rst, r.stall, r.src, r.bt, r.conba, r.jt, r.dba, r.exc, r.irq);
        #1;
        chk({tag, " PC"}, PC, r.e_pc);
        chk({tag, " PCplus4"}, PCplus4, r.e_p4);
        chk({tag, " IntTaken"}, 32'(IntTaken), 32'(r.e_int));
        chk({tag, " ExcTaken"}, 32'(ExcTaken), 32'(r.e_exc));
        chk({tag, " EPC"}, EPC, r.e_exc ? r.e_p4 : r.e_pc);
        @(posedge clk);
        #1;
        chk({tag, " irq_pend"}, 32'(dut.irq_pend_q), 32'(r.e_pend));
    endtask

    // Reference model state: architectural PC and pending-interrupt flag.
    logic [31:0] m_pc;
    logic        m_pend;

    function automatic logic [31:0] seq_next(logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    row_t tbl[$];
    row_t hand[$];

    initial begin
        drive(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset PC", PC, RESET_PC);
        chk("reset PCplus4", PCplus4, 32'h8000_0004);
        chk("reset IntTaken", 32'(IntTaken), 32'd0);
        chk("reset ExcTaken", 32'(ExcTaken), 32'd0);
        chk("reset EPC", EPC, 32'h8000_0000);
        chk("reset irq_pend", 32'(dut.irq_pend_q), 32'd0);

        //           rst stl src bt conba          jt      dba            exc irq pc             p4             int exc pend
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_0000, 32'h8000_0004, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_0004, 32'h8000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_0008, 32'h8000_000C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_000C, 32'h8000_0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h0000_0040, 0, 0, 32'h8000_0010, 32'h8000_0014, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h8000_0100, 0,     0,             0, 0, 32'h0000_0040, 32'h0000_0044, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 1, 32'h0000_0100, 32'h0000_0104, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h0000_0104, 32'h0000_0108, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_0004, 32'h8000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 1, 32'h8000_0008, 32'h8000_000C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h8000_000C, 32'h8000_0010, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h0000_0200, 0, 0, 32'h8000_0010, 32'h8000_0014, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h0000_0200, 32'h0000_0204, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h8000_0020, 0, 0, 32'h8000_0004, 32'h8000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0,            26'h10, 0,             0, 0, 32'h8000_0020, 32'h8000_0024, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 1, 32'h8000_0040, 32'h8000_0044, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h0000_0300, 0, 0, 32'h8000_0044, 32'h8000_0048, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             1, 0, 32'h0000_0300, 32'h0000_0304, 0, 1, 1));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h0000_0400, 0, 0, 32'h8000_0008, 32'h8000_000C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h8000_0500, 0, 0, 32'h0000_0400, 32'h0000_0404, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h0000_0600, 0, 0, 32'h8000_0004, 32'h8000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h8000_0500, 0, 0, 32'h0000_0600, 32'h0000_0604, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 32'h8000_0900, 0,     0,             0, 0, 32'h0000_0500, 32'h0000_0504, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h0000_0504, 32'h0000_0508, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 0, 0,            0,      32'h7FFF_FFFC, 0, 0, 32'h0000_0508, 32'h0000_050C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h7FFF_FFFC, 32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,            0,      0,             0, 0, 32'h0000_0000, 32'h0000_0004, 0, 0, 0));

        // Stall with Exc held, IRQ during stall, release, then reset mid-stall.
        hand.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0004, 32'h0000_0008, 0, 0, 0));
        hand.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0004, 32'h0000_0008, 0, 0, 1));
        hand.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0004, 32'h0000_0008, 0, 0, 1));
        hand.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0004, 32'h0000_0008, 0, 1, 1));
        hand.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0008, 32'h8000_000C, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
        foreach (hand[i]) apply(hand[i], $sformatf("stall%0d", i));
        chk("stall-reset PC", PC, RESET_PC);

        // Randomized run against the reference model.
        m_pc   = RESET_PC;
        m_pend = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst, r_stall, r_exc, r_irq, r_bt;
            logic [1:0]  r_src;
            logic [31:0] r_conba, r_dba, nxt, p4;
            logic [25:0] r_jt;
            logic        kern, exc_t, int_t;
            r_rst   = ($urandom_range(0, 99) < 3);
            r_stall = ($urandom_range(0, 99) < 20);
            r_exc   = ($urandom_range(0, 99) < 10);
            r_irq   = ($urandom_range(0, 99) < 15);
            r_bt    = 1'($urandom);
            r_src   = 2'($urandom);
            r_conba = $urandom;
            r_dba   = $urandom;
            r_jt    = 26'($urandom);

            kern  = (m_pc >= 32'h8000_0000);
            p4    = seq_next(m_pc);
            exc_t = r_exc && !r_stall;
            int_t = m_pend && !kern && !r_exc && !r_stall;

            if (r_rst)      nxt = RESET_PC;
            else if (r_stall) nxt = m_pc;
            else if (exc_t) nxt = XADR_PC;
            else if (int_t) nxt = ILLOP_PC;
            else if (r_src == 2'd0) nxt = p4;
            else if (r_src == 2'd1) nxt = r_bt ? ((m_pc & 32'h8000_0000) | (r_conba & 32'h7FFF_FFFF)) : p4;
            else if (r_src == 2'd2) nxt = (m_pc & 32'h8000_0000) | (p4 & 32'h7000_0000) | (32'(r_jt) * 4);
            else nxt = ((kern && r_dba[31]) ? 32'h8000_0000 : 32'h0) | (r_dba & 32'h7FFF_FFFF);

            @(negedge clk);
            drive(r_rst, r_stall, r_src, r_bt, r_conba, r_jt, r_dba, r_exc, r_irq);
            #1;
            chk("rand PC", PC, m_pc);
            chk("rand PCplus4", PCplus4, p4);
            chk("rand IntTaken", 32'(IntTaken), 32'(int_t));
            chk("rand ExcTaken", 32'(ExcTaken), 32'(exc_t));
            chk("rand EPC", EPC, exc_t ? p4 : m_pc);
            @(posedge clk);
            #1;
            m_pend = r_rst ? 1'b0 : (r_irq ? 1'b1 : (int_t ? 1'b0 : m_pend));
            m_pc   = nxt;
            chk("rand next PC", PC, m_pc);
            chk("rand irq_pend", 32'(dut.irq_pend_q), 32'(m_pend));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and next-PC selection for the single-cycle MIPS datapath. It sits directly upstream of the immediate-extension/branch-target stage: it supplies `PCplus4` (consumed there to form the branch target) and takes the resulting branch target `ConBA` back in for the next-PC choice. It also owns the supervisor bit `PC[31]`, the pending-interrupt latch, and a fetch-stall hold.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded by reset; kernel mode.
- `ILLOP_PC`, 32'h8000_0004, interrupt vector.
- `XADR_PC`, 32'h8000_0008, exception (illegal op / undefined instruction) vector.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PCSrc`  in  2  next-PC select: 0 PC+4, 1 branch, 2 jump, 3 jump-register.
- `BranchTaken`  in  1  branch condition from the ALU; only meaningful when `PCSrc==1`.
- `ConBA`  in  32  branch target from the extension stage.
- `JT`  in  26  instruction jump field.
- `DatabusA`  in  32  register rs value for jr/jalr.
- `Exc`  in  1  control unit flags an illegal or undefined instruction this cycle.
- `IRQ`  in  1  level interrupt request from the timer or peripheral.
- `Stall`  in  1  instruction memory not ready; hold the PC.
- `PC`  out  32  current instruction address.
- `PCplus4`  out  32  sequential successor, combinational from `PC`.
- `IntTaken`  out  1  combinational; this cycle is redirected to `ILLOP_PC`.
- `ExcTaken`  out  1  combinational; this cycle is redirected to `XADR_PC`.
- `EPC`  out  32  return address to write into $k0 on redirect. Equals `PC` for an interrupt and `PCplus4` for an exception.

## Operation
- `PCplus4 = {PC[31], PC[30:0] + 31'd4}`.
  - The carry out of bit 30 is discarded.
  - Bit 31 never changes by sequential increment.
- Kernel mode is defined as `PC[31]==1`.
- Pending-interrupt latch `irq_pend`:
  - Set on any edge where `IRQ==1`.
  - Cleared only on the edge where `IntTaken==1`, or by reset.
  - Set has priority over clear when `IRQ` is still high on the taking edge, so the interrupt re-pends.
- Redirect conditions:
  - `IntTaken = irq_pend & ~PC[31] & ~Exc & ~Stall`.
  - `ExcTaken = Exc & ~Stall`.
- Next-PC priority, highest first:
  1. `reset` loads `RESET_PC`.
  2. `Stall` holds `PC`.
  3. `ExcTaken` loads `XADR_PC`.
  4. `IntTaken` loads `ILLOP_PC`.
  5. Otherwise `PCSrc` selects:
     - 0: `PCplus4`.
     - 1: `BranchTaken ? {PC[31], ConBA[30:0]} : PCplus4`.
     - 2: `{PC[31], PCplus4[30:28], JT, 2'b00}`.
     - 3: `{PC[31] & DatabusA[31], DatabusA[30:0]}`.
- Supervisor-bit rules:
  - Branch and jump never alter `PC[31]`.
  - jr can clear it (return from handler to user), never set it.
  - Only reset, exception or interrupt enters kernel mode.
- Exceptions are taken in kernel mode as well. Interrupts are masked in kernel mode and stay pending.
- Reserved behaviour: `PCSrc==1` with `BranchTaken==0` falls through to `PCplus4`.

## Timing
- Reset values:
  - `PC = RESET_PC`, `irq_pend = 0`.
  - `PCplus4 = 32'h8000_0004`.
  - `IntTaken = 0`, `ExcTaken = 0`.
  - `EPC = 32'h8000_0000`.
- Latency:
  - Next-PC selection is combinational from the inputs.
  - `PC` updates one edge later, giving one instruction per cycle when `Stall==0`.
- An `IRQ` asserted in cycle n sets `irq_pend` at edge n. The earliest redirect is the edge ending cycle n+1, provided the CPU is in user mode and no stall or exception is present.
- Stall:
  - `PC` and all decisions freeze.
  - `irq_pend` still sets.
  - A stalled `Exc` produces no redirect until `Stall` falls.
- Reset asserted mid-stall or with a pending interrupt: reset wins and `irq_pend` clears. This holds even if `IRQ==1` on that edge.
- Simultaneous `Exc` and pending interrupt: the exception is taken and the interrupt remains pending.
- Address wrap: `PC = 32'h7FFF_FFFC` gives `PCplus4 = 32'h0000_0000`. This is the user-space wrap; kernel mode is not entered.

## Test plan
- Reset, then 3 cycles with `PCSrc=0`:
  - `PC` sequence 8000_0000 → 8000_0004 → 8000_0008 → 8000_000C.
- jr to user mode, then branch:
  - From `PC = 8000_0010`, `PCSrc=3`, `DatabusA=0000_0040` → `PC = 0000_0040`.
  - Next, `PCSrc=1`, `BranchTaken=1`, `ConBA=8000_0100` → `PC = 0000_0100`. Bit 31 is not set.
- Jump in kernel mode:
  - `PC = 8000_0020`, `PCSrc=2`, `JT=26'h0000010` → `PC = 8000_0040`.
- Interrupt from user mode:
  - `PC = 0000_0100`, pulse `IRQ` for 1 cycle.
  - Next cycle `IntTaken=1` with `EPC = 0000_0104`, then `PC = 8000_0004`.
  - While in kernel mode, a further `IRQ` pulse leaves `irq_pend=1` with no redirect.
  - After jr to 0000_0200, the redirect occurs on the next cycle.
- Exception racing interrupt:
  - `irq_pend=1`, user mode, `Exc=1`, `PC = 0000_0300`.
  - Required: `ExcTaken=1`, `EPC = 0000_0304`, next `PC = 8000_0008`, `irq_pend` still 1.
- Stall and reset:
  - Hold `Stall=1` for 3 cycles with `Exc=1`: `PC` unchanged and `ExcTaken=0` throughout.
  - Assert `reset` during the stall with `IRQ=1`: `PC = 8000_0000`, `irq_pend = 0`.
